// File: rtl/dac_arb_pkg.sv
// Shared types and constants for the DAC ownership arbiter.
package dac_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    GUARD = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE  = 2'd0;
  localparam logic [1:0] OWNER_REQ0  = 2'd1;
  localparam logic [1:0] OWNER_REQ1  = 2'd2;
  localparam logic [1:0] OWNER_GUARD = 2'd3;

  // Two's complement midscale is all zeros; replicate to DATA_WIDTH at use.
  localparam logic MIDSCALE_BIT = 1'b0;

  // One-hot pick; on a tie the requester that did not own last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_owner);
    logic [1:0] pick;
    pick = req;
    if (&req) pick = last_owner ? 2'b01 : 2'b10;
    return pick;
  endfunction

endpackage

// File: rtl/dac_arb_guard_cnt.sv
// Loadable down-counter with terminal-count flag; used for the guard
// interval and for the owner watchdog.
module dac_arb_guard_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= load_val_i;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/dac_owner_arbiter.sv
// Round-robin owner arbiter for the DAC datapath with a midscale guard gap.
// Optional owner watchdog is built when DAC_ARB_TIMEOUT_EN is defined.
module dac_owner_arbiter
  import dac_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 14,
  parameter int GUARD_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rst_i,
  input  logic [1:0]            req_i,
  output logic [1:0]            gnt_o,
  input  logic [DATA_WIDTH-1:0] s0_dat_a_i,
  input  logic [DATA_WIDTH-1:0] s0_dat_b_i,
  input  logic                  s0_valid_i,
  input  logic [DATA_WIDTH-1:0] s1_dat_a_i,
  input  logic [DATA_WIDTH-1:0] s1_dat_b_i,
  input  logic                  s1_valid_i,
  output logic [DATA_WIDTH-1:0] dac_dat_a_o,
  output logic [DATA_WIDTH-1:0] dac_dat_b_o,
  output logic                  dac_dat_a_en_o,
  output logic                  dac_dat_b_en_o,
  output logic [1:0]            owner_o,
  output logic                  timeout_o
);

  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {DATA_WIDTH{MIDSCALE_BIT}};
  localparam logic [7:0]            G_LOAD   = 8'(GUARD_CYCLES - 1);

  if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("dac_owner_arbiter: GUARD_CYCLES must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] dat_a_q, dat_a_d, dat_b_q, dat_b_d;
  logic                  en_q, en_d, tmo_q, g_first_q, g_first_d;
  logic [1:0]            eff_req, pick;
  logic                  g_tc, tmo;

  // Counter reloads whenever we are outside GUARD, so it starts full on entry.
  dac_arb_guard_cnt #(.WIDTH(8)) u_guard_cnt (
    .clk_i      (dac_clk_i),
    .rst_i      (dac_rst_i),
    .load_i     (state_q != GUARD),
    .load_val_i (G_LOAD),
    .dec_i      (1'b1),
    .tc_o       (g_tc)
  );

`ifdef DAC_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic       own_idle, wd_tc;
  logic [1:0] blk_q, blk_d;

  assign own_idle = (state_q == OWN0 && !s0_valid_i) || (state_q == OWN1 && !s1_valid_i);

  dac_arb_guard_cnt #(.WIDTH(WW)) u_wd_cnt (
    .clk_i      (dac_clk_i),
    .rst_i      (dac_rst_i),
    .load_i     (!own_idle),
    .load_val_i (WW'(TIMEOUT_CYCLES - 1)),
    .dec_i      (1'b1),
    .tc_o       (wd_tc)
  );

  assign tmo = own_idle && wd_tc;

  // A revoked requester stays masked until its request is seen low.
  always_comb begin
    blk_d = blk_q;
    if (tmo && state_q == OWN0) blk_d[0] = 1'b1;
    if (tmo && state_q == OWN1) blk_d[1] = 1'b1;
    blk_d = blk_d & req_i;
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) blk_q <= 2'b00;
    else           blk_q <= blk_d;
  end

  assign eff_req = req_i & ~blk_q;
`else
  assign tmo     = 1'b0;
  assign eff_req = req_i;
`endif

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pick    = rr_pick(eff_req, last_q);
    case (state_q)
      IDLE: begin
        if (pick[0])      state_d = OWN0;
        else if (pick[1]) state_d = OWN1;
      end
      OWN0: if (!req_i[0] || tmo) begin
        state_d = GUARD;
        last_d  = 1'b0;
      end
      OWN1: if (!req_i[1] || tmo) begin
        state_d = GUARD;
        last_d  = 1'b1;
      end
      default: if (g_tc) begin
        if (pick[0])      state_d = OWN0;
        else if (pick[1]) state_d = OWN1;
        else              state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    dat_a_d   = dat_a_q;
    dat_b_d   = dat_b_q;
    en_d      = 1'b0;
    g_first_d = (state_d == GUARD) && (state_q != GUARD);
    gnt_o     = {state_q == OWN1, state_q == OWN0};
    owner_o   = OWNER_GUARD;
    case (state_q)
      IDLE: owner_o = OWNER_NONE;
      OWN0: begin
        owner_o = OWNER_REQ0;
        if (s0_valid_i) begin
          dat_a_d = s0_dat_a_i;
          dat_b_d = s0_dat_b_i;
          en_d    = 1'b1;
        end
      end
      OWN1: begin
        owner_o = OWNER_REQ1;
        if (s1_valid_i) begin
          dat_a_d = s1_dat_a_i;
          dat_b_d = s1_dat_b_i;
          en_d    = 1'b1;
        end
      end
      default: begin
        dat_a_d = MIDSCALE;
        dat_b_d = MIDSCALE;
        en_d    = g_first_q;
      end
    endcase
  end

  // Enables come out of reset high so the DAC stage loads midscale once.
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      dat_a_q   <= MIDSCALE;
      dat_b_q   <= MIDSCALE;
      en_q      <= 1'b1;
      tmo_q     <= 1'b0;
      g_first_q <= 1'b0;
    end else begin
      dat_a_q   <= dat_a_d;
      dat_b_q   <= dat_b_d;
      en_q      <= en_d;
      tmo_q     <= tmo;
      g_first_q <= g_first_d;
    end
  end

  assign dac_dat_a_o    = dat_a_q;
  assign dac_dat_b_o    = dat_b_q;
  assign dac_dat_a_en_o = en_q;
  assign dac_dat_b_en_o = en_q;
  assign timeout_o      = tmo_q;

endmodule

// File: tb/tb_dac_owner_arbiter.sv
// Vector-table bench for dac_owner_arbiter; expected outputs ride a
// scoreboard queue and are compared one cycle after the stimulus.
module tb_dac_owner_arbiter;

  localparam int DW = 14;
  localparam int G  = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [DW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [1:0]    gnt, own;
  logic [DW-1:0] da, db;
  logic          ena, enb, tmo;

  always #5 clk = ~clk;

  dac_owner_arbiter #(.DATA_WIDTH(DW), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
    .dac_clk_i(clk), .dac_rst_i(rst), .req_i(req), .gnt_o(gnt),
    .s0_dat_a_i(a0), .s0_dat_b_i(b0), .s0_valid_i(v0),
    .s1_dat_a_i(a1), .s1_dat_b_i(b1), .s1_valid_i(v1),
    .dac_dat_a_o(da), .dac_dat_b_o(db), .dac_dat_a_en_o(ena), .dac_dat_b_en_o(enb),
    .owner_o(own), .timeout_o(tmo)
  );

  typedef struct {
    logic          rst;
    logic [1:0]    req;
    logic          v0;
    logic [DW-1:0] a0, b0;
    logic          v1;
    logic [DW-1:0] a1, b1;
    logic [1:0]    gnt, own;
    logic [DW-1:0] ea, eb;
    logic          en, tmo;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic [1:0] rq,
                     input logic sv0, input logic [DW-1:0] sa0, sb0,
                     input logic sv1, input logic [DW-1:0] sa1, sb1,
                     input logic [1:0] egnt, eown, input logic [DW-1:0] ea, eb,
                     input logic een, etmo);
    vec_t v;
    v.rst = r;  v.req = rq;
    v.v0 = sv0; v.a0 = sa0; v.b0 = sb0;
    v.v1 = sv1; v.a1 = sa1; v.b1 = sb1;
    v.gnt = egnt; v.own = eown; v.ea = ea; v.eb = eb; v.en = een; v.tmo = etmo;
    vecs.push_back(v);
  endtask

  task automatic addi(input logic [1:0] rq, input logic [1:0] egnt, eown,
                      input logic [DW-1:0] ea, eb, input logic een, etmo);
    add(1'b0, rq, 1'b0, '0, '0, 1'b0, '0, '0, egnt, eown, ea, eb, een, etmo);
  endtask

  // G guard cycles after a release; request switches from rq_a to rq_b at step sw.
  task automatic add_guard(input logic [1:0] rq_a, rq_b, input int sw,
                           input logic [1:0] end_gnt, end_own);
    for (int i = 0; i < G; i++) begin
      if (i == G - 1) addi((i < sw) ? rq_a : rq_b, end_gnt, end_own, '0, '0, 1'b0, 1'b0);
      else            addi((i < sw) ? rq_a : rq_b, 2'b00, 2'd3, '0, '0, i == 0, 1'b0);
    end
  endtask

  initial begin
    vec_t e;
    bit   done;
    for (int i = 0; i < 3; i++)
      add(1'b1, 2'b00, 1'b0, '0, '0, 1'b0, '0, '0, 2'b00, 2'd0, '0, '0, 1'b1, 1'b0);
    // contention from reset: requester 0 wins, s1 data is ignored
    addi(2'b11, 2'b01, 2'd1, '0, '0, 1'b0, 1'b0);
    add(1'b0, 2'b11, 1'b1, 14'h1234, 14'h0ABC, 1'b1, 14'h1777, 14'h1666,
        2'b01, 2'd1, 14'h1234, 14'h0ABC, 1'b1, 1'b0);
    add(1'b0, 2'b11, 1'b0, '0, '0, 1'b1, 14'h0333, 14'h0444,
        2'b01, 2'd1, 14'h1234, 14'h0ABC, 1'b0, 1'b0);
    add(1'b0, 2'b10, 1'b1, 14'h0555, 14'h0AAA, 1'b0, '0, '0,
        2'b00, 2'd3, 14'h0555, 14'h0AAA, 1'b1, 1'b0);
    add_guard(2'b10, 2'b10, 0, 2'b10, 2'd2);
    // req0 back up while s1 owns: no preemption
    add(1'b0, 2'b11, 1'b1, 14'h0FFF, 14'h0FFF, 1'b1, 14'h1357, 14'h2468,
        2'b10, 2'd2, 14'h1357, 14'h2468, 1'b1, 1'b0);
    addi(2'b11, 2'b10, 2'd2, 14'h1357, 14'h2468, 1'b0, 1'b0);
    addi(2'b01, 2'b00, 2'd3, 14'h1357, 14'h2468, 1'b0, 1'b0);
    add_guard(2'b01, 2'b01, 0, 2'b01, 2'd1);
    addi(2'b11, 2'b01, 2'd1, '0, '0, 1'b0, 1'b0);
    addi(2'b10, 2'b00, 2'd3, '0, '0, 1'b0, 1'b0);
    add_guard(2'b11, 2'b11, 0, 2'b10, 2'd2);
    addi(2'b00, 2'b00, 2'd3, '0, '0, 1'b0, 1'b0);
    add_guard(2'b00, 2'b00, 0, 2'b00, 2'd0);
    // single owner, then release and re-request on guard cycle 3
    addi(2'b01, 2'b01, 2'd1, '0, '0, 1'b0, 1'b0);
    add(1'b0, 2'b01, 1'b1, 14'h1234, 14'h0ABC, 1'b0, '0, '0,
        2'b01, 2'd1, 14'h1234, 14'h0ABC, 1'b1, 1'b0);
    addi(2'b00, 2'b00, 2'd3, 14'h1234, 14'h0ABC, 1'b0, 1'b0);
    add_guard(2'b00, 2'b01, 3, 2'b01, 2'd1);
    addi(2'b00, 2'b00, 2'd3, '0, '0, 1'b0, 1'b0);
    add_guard(2'b00, 2'b00, 0, 2'b00, 2'd0);
    // owner holds request with no samples
    addi(2'b01, 2'b01, 2'd1, '0, '0, 1'b0, 1'b0);
`ifdef DAC_ARB_TIMEOUT_EN
    for (int k = 1; k < TO; k++) addi(2'b01, 2'b01, 2'd1, '0, '0, 1'b0, 1'b0);
    addi(2'b01, 2'b00, 2'd3, '0, '0, 1'b0, 1'b1);
    add_guard(2'b01, 2'b01, 0, 2'b00, 2'd0);
    addi(2'b01, 2'b00, 2'd0, '0, '0, 1'b0, 1'b0);
    addi(2'b00, 2'b00, 2'd0, '0, '0, 1'b0, 1'b0);
    addi(2'b01, 2'b01, 2'd1, '0, '0, 1'b0, 1'b0);
`else
    for (int k = 0; k < 3 * TO; k++) addi(2'b01, 2'b01, 2'd1, '0, '0, 1'b0, 1'b0);
`endif

    // reset-state check
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt, own, da, db, tmo} !== {2'b00, 2'd0, {DW{1'b0}}, {DW{1'b0}}, 1'b0} || ena !== enb) begin
      failures++;
      $display("FAIL reset state gnt=%b own=%0d a=%h b=%h en=%b%b tmo=%b",
               gnt, own, da, db, ena, enb, tmo);
    end

    foreach (vecs[k]) begin
      rst = vecs[k].rst; req = vecs[k].req;
      v0 = vecs[k].v0; a0 = vecs[k].a0; b0 = vecs[k].b0;
      v1 = vecs[k].v1; a1 = vecs[k].a1; b1 = vecs[k].b1;
      sb.push_back(vecs[k]);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({gnt, own, da, db, ena, enb, tmo} !== {e.gnt, e.own, e.ea, e.eb, e.en, e.en, e.tmo}) begin
        failures++;
        $display("FAIL step%0d got gnt=%b own=%0d a=%h b=%h en=%b%b tmo=%b want gnt=%b own=%0d a=%h b=%h en=%b%b tmo=%b",
                 k, gnt, own, da, db, ena, enb, tmo, e.gnt, e.own, e.ea, e.eb, e.en, e.en, e.tmo);
      end
    end

    // release everything; arbiter must return to idle within a bounded wait
    req = 2'b00; v0 = 1'b0; v1 = 1'b0;
    done = 1'b0;
    for (int w = 0; w < 4 * G && !done; w++) begin
      @(posedge clk);
      @(negedge clk);
      if (gnt === 2'b00 && own === 2'd0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL idle wait expired gnt=%b own=%0d", gnt, own);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
